// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encodings for the sequential ALU.
// Optional iterative MUL/DIV/REM is enabled by ALU_SEQ_MULDIV_EN.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'd0;
    localparam logic [OP_W-1:0] OP_OR  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_XOR = 4'd3;
    localparam logic [OP_W-1:0] OP_NOR = 4'd4;
    localparam logic [OP_W-1:0] OP_SRL = 4'd5;
    localparam logic [OP_W-1:0] OP_SUB = 4'd6;
    localparam logic [OP_W-1:0] OP_SLT = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL = 4'd8;
    localparam logic [OP_W-1:0] OP_DIV = 4'd9;
    localparam logic [OP_W-1:0] OP_REM = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned multiplier / restoring divider.
// Used by alu_seq_muldiv only when ALU_SEQ_MULDIV_EN is defined.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            last,
    output logic [W-1:0]    result
);

    localparam int CW = $clog2(W);

    // acc: product (MUL) or partial remainder (DIV/REM)
    // opa: shifting multiplicand, or dividend turning into quotient
    // opb: shifting multiplier, or the fixed divisor
    logic          busy;
    logic          is_div;
    logic          is_rem;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;

    logic [W:0]    trial;
    logic [W:0]    diff;
    logic          ge;
    logic [W-1:0]  acc_nx;
    logic [W-1:0]  opa_nx;
    logic [W-1:0]  opb_nx;

    // One iteration step of whichever algorithm is running
    always_comb begin
        trial = {acc, opa[W-1]};
        diff  = trial - {1'b0, opb};
        ge    = trial >= {1'b0, opb};
        if (is_div) begin
            acc_nx = ge ? diff[W-1:0] : trial[W-1:0];
            opa_nx = {opa[W-2:0], ge};
            opb_nx = opb;
        end else begin
            acc_nx = acc + (opb[0] ? opa : '0);
            opa_nx = opa << 1;
            opb_nx = opb >> 1;
        end
    end

    // Load operands on start, then step W times
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            is_div <= 1'b0;
            is_rem <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            is_div <= (op != OP_MUL);
            is_rem <= (op == OP_REM);
            cnt    <= '0;
            acc    <= '0;
            opa    <= a;
            opb    <= b;
        end else if (busy) begin
            acc <= acc_nx;
            opa <= opa_nx;
            opb <= opb_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

    // last flags the cycle whose step completes the operation
    assign last   = busy && (cnt == CW'(W - 1));
    assign result = (is_div && !is_rem) ? opa : acc;

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered, handshaked ALU with optional iterative MUL/DIV/REM.
// Define ALU_SEQ_MULDIV_EN to build the iterative datapath.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    input  logic [OP_W-1:0] ALU_operation,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    res,
    output logic            zero,
    output logic            overflow,
    output logic            div0
);

    logic [W-1:0] sum;
    logic [W-1:0] dif;
    logic [W-1:0] sc_res;
    logic         sc_ovf;
    logic         sc_div0;
    logic         sc_legal;
    logic         go_iter;
    logic         idle;
    logic         accept;
    logic         load_iter;
    logic [W-1:0] it_res;

    // Single-cycle results and the decision to start an iteration
    always_comb begin
        sum      = A + B;
        dif      = A - B;
        sc_res   = '0;
        sc_ovf   = 1'b0;
        sc_div0  = 1'b0;
        sc_legal = 1'b1;
        go_iter  = 1'b0;
        unique case (ALU_operation)
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
            end
            OP_XOR: sc_res = A ^ B;
            OP_NOR: sc_res = ~(A | B);
            OP_SRL: sc_res = A >> B[SHW-1:0];
            OP_SUB: begin
                sc_res = dif;
                sc_ovf = (A[W-1] != B[W-1]) && (dif[W-1] != A[W-1]);
            end
            OP_SLT: sc_res = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL: go_iter = 1'b1;
            OP_DIV: begin
                if (B == '0) begin
                    sc_res  = '1;
                    sc_div0 = 1'b1;
                end else begin
                    go_iter = 1'b1;
                end
            end
            OP_REM: begin
                if (B == '0) begin
                    sc_res  = A;
                    sc_div0 = 1'b1;
                end else begin
                    go_iter = 1'b1;
                end
            end
`endif
            default: sc_legal = 1'b0;
        endcase
    end

    assign in_ready = idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MULDIV_EN
    state_t state;
    state_t state_nx;
    logic   it_start;
    logic   it_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: IDLE -> ITER -> DONE -> IDLE for iterative ops
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept && go_iter) state_nx = ST_ITER;
            ST_ITER: if (it_last) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        idle      = (state == ST_IDLE);
        it_start  = accept && go_iter;
        load_iter = (state == ST_DONE);
    end

    alu_muldiv_iter #(
        .W(W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (it_start),
        .op     (ALU_operation),
        .a      (A),
        .b      (B),
        .last   (it_last),
        .result (it_res)
    );
`else
    assign idle      = 1'b1;
    assign load_iter = 1'b0;
    assign it_res    = '0;
`endif

    // Output register: load on single-cycle accept or iteration end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res       <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            div0      <= 1'b0;
        end else if (accept && !go_iter) begin
            out_valid <= 1'b1;
            res       <= sc_res;
            zero      <= sc_legal && (sc_res == '0);
            overflow  <= sc_ovf;
            div0      <= sc_div0;
        end else if (load_iter) begin
            out_valid <= 1'b1;
            res       <= it_res;
            zero      <= (it_res == '0);
            overflow  <= 1'b0;
            div0      <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
